// File: rtl/muldiv_ctrl.sv
// Sequencer between the decode stage and the iterative multiply/divide units.
// Issues start pulses, stalls until done, and owns the HI/LO registers and MFHI/MFLO read path.
module muldiv_ctrl #(
    parameter int unsigned TIMEOUT = 40
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        i_req,
    input  logic [2:0]  i_op,
    input  logic [31:0] i_rs_val,
    input  logic [31:0] i_rt_val,
    output logic [31:0] o_mult_a,
    output logic [31:0] o_mult_b,
    output logic        o_multControl,
    input  logic        i_multStop,
    input  logic [31:0] i_mult_hi,
    input  logic [31:0] i_mult_lo,
    output logic [31:0] o_div_a,
    output logic [31:0] o_div_b,
    output logic        o_divControl,
    input  logic        i_divStop,
    input  logic [31:0] i_div_hi,
    input  logic [31:0] i_div_lo,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic [31:0] o_rd_data,
    output logic        o_rd_valid,
    output logic        o_stall,
    output logic        o_div0,
    output logic        o_timeout_err
);

    localparam logic [2:0] OpMult = 3'b000;
    localparam logic [2:0] OpDiv  = 3'b001;
    localparam logic [2:0] OpMthi = 3'b010;
    localparam logic [2:0] OpMtlo = 3'b011;
    localparam logic [2:0] OpMfhi = 3'b100;
    localparam logic [2:0] OpMflo = 3'b101;

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStartMul,
        StWaitMul,
        StStartDiv,
        StWaitDiv
    } state_e;

    state_e          r_state;
    logic [CntW-1:0] r_cnt;
    logic [31:0]     r_mult_a, r_mult_b, r_div_a, r_div_b;
    logic [31:0]     r_hi, r_lo, r_rd_data;
    logic            r_multControl, r_divControl, r_rd_valid, r_div0, r_timeout_err;
    logic            w_accept;

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state       <= StIdle;
            r_cnt         <= '0;
            r_mult_a      <= '0;
            r_mult_b      <= '0;
            r_div_a       <= '0;
            r_div_b       <= '0;
            r_hi          <= '0;
            r_lo          <= '0;
            r_rd_data     <= '0;
            r_multControl <= 1'b0;
            r_divControl  <= 1'b0;
            r_rd_valid    <= 1'b0;
            r_div0        <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_multControl <= 1'b0;
            r_divControl  <= 1'b0;
            r_rd_valid    <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_req) begin
                        case (i_op)
                            OpMult: begin
                                r_mult_a      <= i_rs_val;
                                r_mult_b      <= i_rt_val;
                                r_multControl <= 1'b1;
                                r_state       <= StStartMul;
                            end
                            OpDiv: begin
                                if (i_rt_val == '0) begin
                                    r_div0 <= 1'b1;
                                end else begin
                                    r_div_a      <= i_rs_val;
                                    r_div_b      <= i_rt_val;
                                    r_divControl <= 1'b1;
                                    r_state      <= StStartDiv;
                                end
                            end
                            OpMthi: r_hi <= i_rs_val;
                            OpMtlo: r_lo <= i_rs_val;
                            OpMfhi: begin
                                r_rd_data  <= r_hi;
                                r_rd_valid <= 1'b1;
                            end
                            OpMflo: begin
                                r_rd_data  <= r_lo;
                                r_rd_valid <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                // Done is not sampled here: it may be stale until the unit sees this start edge.
                StStartMul: begin
                    r_cnt   <= '0;
                    r_state <= StWaitMul;
                end
                StStartDiv: begin
                    r_cnt   <= '0;
                    r_state <= StWaitDiv;
                end
                StWaitMul: begin
                    if (i_multStop) begin
                        r_hi    <= i_mult_hi;
                        r_lo    <= i_mult_lo;
                        r_state <= StIdle;
                    end else if (r_cnt == CntMax) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= StIdle;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StWaitDiv: begin
                    if (i_divStop) begin
                        r_hi    <= i_div_hi;
                        r_lo    <= i_div_lo;
                        r_state <= StIdle;
                    end else if (r_cnt == CntMax) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= StIdle;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Stall must rise in the acceptance cycle itself so upstream holds the next instruction.
    assign w_accept = i_req && ((i_op == OpMult) || ((i_op == OpDiv) && (i_rt_val != '0)));
    assign o_stall  = (r_state != StIdle) || w_accept;

    assign o_mult_a      = r_mult_a;
    assign o_mult_b      = r_mult_b;
    assign o_multControl = r_multControl;
    assign o_div_a       = r_div_a;
    assign o_div_b       = r_div_b;
    assign o_divControl  = r_divControl;
    assign o_hi          = r_hi;
    assign o_lo          = r_lo;
    assign o_rd_data     = r_rd_data;
    assign o_rd_valid    = r_rd_valid;
    assign o_div0        = r_div0;
    assign o_timeout_err = r_timeout_err;

endmodule
